// File: rtl/bidir_link_arbiter_pkg.sv
// Shared types and default sizing for the bidirectional link arbiter.
package bidir_link_pkg;

  typedef enum logic [1:0] {IDLE, START, XFER, TURN} link_state_e;
  typedef enum logic {SIDE_PHY, SIDE_MEM} link_side_e;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_XFER_CYCLES = 12;
  localparam int DEF_TA_CYCLES   = 2;

  // Down-counter width that holds the larger of the two window lengths.
  function automatic int cnt_width(input int xfer, input int ta);
    int m;
    m = (xfer > ta) ? xfer : ta;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/bidir_link_arbiter_if.sv
// Request/grant bundle between the two requesters, the arbiter and the wrappers.
interface bidir_link_arbiter_if #(
  parameter int DATA_W = 8
);
  logic              phy_req;
  logic [DATA_W-1:0] phy_req_data;
  logic              mem_req;
  logic [DATA_W-1:0] mem_req_data;
  logic              phy_ack;
  logic              mem_ack;
  logic              phy_start;
  logic [DATA_W-1:0] phy_data;
  logic              mem_start;
  logic [DATA_W-1:0] mem_data;
  logic              phy_own;
  logic              mem_own;
  logic              busy;

  modport slave (
    input  phy_req, phy_req_data, mem_req, mem_req_data,
    output phy_ack, mem_ack, phy_start, phy_data, mem_start, mem_data,
           phy_own, mem_own, busy
  );

  modport master (
    output phy_req, phy_req_data, mem_req, mem_req_data,
    input  phy_ack, mem_ack, phy_start, phy_data, mem_start, mem_data,
           phy_own, mem_own, busy
  );
endinterface

// File: rtl/bidir_link_arbiter_rr_pick2.sv
// Two-requester round-robin picker: combinational grant, registered last winner.
module rr_pick2
  import bidir_link_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req_phy,
  input  logic       req_mem,
  input  logic       take,
  output logic       grant_vld,
  output link_side_e grant_side
);

  link_side_e rr_last;

  // On a tie the side that did not win last time is chosen.
  always_comb begin
    grant_vld  = req_phy | req_mem;
    grant_side = SIDE_PHY;
    if (req_mem && (!req_phy || rr_last == SIDE_PHY))
      grant_side = SIDE_MEM;
  end

  always_ff @(posedge clk) begin
    if (rst)
      rr_last <= SIDE_MEM;
    else if (take)
      rr_last <= grant_side;
  end

endmodule

// File: rtl/bidir_link_arbiter.sv
// Grants the shared serial link to PHY or MEM side, holds it for a transfer
// window, then idles for a turnaround gap so the two ends never drive together.
module bidir_link_arbiter
  import bidir_link_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int XFER_CYCLES = DEF_XFER_CYCLES,
  parameter int TA_CYCLES   = DEF_TA_CYCLES
) (
  input logic                  clk,
  input logic                  rst,
  bidir_link_arbiter_if.slave  link
);

  localparam int CNT_W = cnt_width(XFER_CYCLES, TA_CYCLES);
  localparam logic [CNT_W-1:0] XFER_LOAD = CNT_W'(XFER_CYCLES - 1);
  localparam logic [CNT_W-1:0] TA_LOAD   = CNT_W'((TA_CYCLES > 0) ? TA_CYCLES - 1 : 0);

  link_state_e       state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              grant_vld, take;
  link_side_e        grant_side;

  logic              phy_ack, mem_ack, phy_start, mem_start, phy_own, mem_own, busy;
  logic [DATA_W-1:0] phy_data, mem_data;
  logic              phy_ack_nx, mem_ack_nx, phy_start_nx, mem_start_nx;
  logic              phy_own_nx, mem_own_nx, busy_nx;
  logic [DATA_W-1:0] phy_data_nx, mem_data_nx;

  assign take = (state == IDLE) && grant_vld;

  rr_pick2 u_pick (
    .clk        (clk),
    .rst        (rst),
    .req_phy    (link.phy_req),
    .req_mem    (link.mem_req),
    .take       (take),
    .grant_vld  (grant_vld),
    .grant_side (grant_side)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE:  if (grant_vld) state_nx = START;
      START: begin
        state_nx = XFER;
        cnt_nx   = XFER_LOAD;
      end
      XFER: begin
        if (cnt == '0) begin
          state_nx = (TA_CYCLES > 0) ? TURN : IDLE;
          cnt_nx   = TA_LOAD;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      TURN: begin
        if (cnt == '0) state_nx = IDLE;
        else           cnt_nx   = cnt - CNT_W'(1);
      end
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs; ack/start fire on the grant edge.
  always_comb begin
    phy_ack_nx   = 1'b0;
    mem_ack_nx   = 1'b0;
    phy_start_nx = 1'b0;
    mem_start_nx = 1'b0;
    phy_own_nx   = phy_own;
    mem_own_nx   = mem_own;
    phy_data_nx  = phy_data;
    mem_data_nx  = mem_data;
    case (state)
      IDLE: begin
        if (grant_vld && grant_side == SIDE_PHY) begin
          phy_ack_nx   = 1'b1;
          phy_start_nx = 1'b1;
          phy_own_nx   = 1'b1;
          phy_data_nx  = link.phy_req_data;
        end else if (grant_vld) begin
          mem_ack_nx   = 1'b1;
          mem_start_nx = 1'b1;
          mem_own_nx   = 1'b1;
          mem_data_nx  = link.mem_req_data;
        end
      end
      XFER: begin
        if (cnt == '0) begin
          phy_own_nx = 1'b0;
          mem_own_nx = 1'b0;
        end
      end
      TURN: begin
        phy_own_nx = 1'b0;
        mem_own_nx = 1'b0;
      end
      default: ;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      phy_ack   <= 1'b0;
      mem_ack   <= 1'b0;
      phy_start <= 1'b0;
      mem_start <= 1'b0;
      phy_own   <= 1'b0;
      mem_own   <= 1'b0;
      busy      <= 1'b0;
      phy_data  <= '0;
      mem_data  <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      phy_ack   <= phy_ack_nx;
      mem_ack   <= mem_ack_nx;
      phy_start <= phy_start_nx;
      mem_start <= mem_start_nx;
      phy_own   <= phy_own_nx;
      mem_own   <= mem_own_nx;
      busy      <= busy_nx;
      phy_data  <= phy_data_nx;
      mem_data  <= mem_data_nx;
    end
  end

  assign link.phy_ack   = phy_ack;
  assign link.mem_ack   = mem_ack;
  assign link.phy_start = phy_start;
  assign link.mem_start = mem_start;
  assign link.phy_own   = phy_own;
  assign link.mem_own   = mem_own;
  assign link.busy      = busy;
  assign link.phy_data  = phy_data;
  assign link.mem_data  = mem_data;

endmodule

// File: tb/tb_bidir_link_arbiter.sv
// Directed bench for bidir_link_arbiter: default build plus a zero-turnaround build.
module tb_bidir_link_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  bit   overlap_seen = 1'b0;

  always #5 clk = ~clk;

  bidir_link_arbiter_if #(.DATA_W(8)) ia ();
  bidir_link_arbiter_if #(.DATA_W(8)) ib ();

  bidir_link_arbiter #(.DATA_W(8), .XFER_CYCLES(12), .TA_CYCLES(2)) dut_a (
    .clk (clk), .rst (rst), .link (ia)
  );
  bidir_link_arbiter #(.DATA_W(8), .XFER_CYCLES(12), .TA_CYCLES(0)) dut_b (
    .clk (clk), .rst (rst), .link (ib)
  );

  always @(negedge clk) begin
    if (!rst && ((ia.phy_own && ia.mem_own) || (ib.phy_own && ib.mem_own) ||
                 (ia.phy_ack && ia.mem_ack) || (ib.phy_start && ib.mem_start)))
      overlap_seen = 1'b1;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle_a(input string tag);
    int n = 0;
    while (ia.busy && n < 50) begin
      step(1);
      n++;
    end
    chk(tag, {31'd0, ia.busy}, 0);
  endtask

  // One side alone: grant one cycle later, 13 cycles of ownership, 2 turnaround cycles.
  task automatic lone(input bit side_phy, input string tag);
    int n;
    bit other_seen;
    if (side_phy) begin ia.phy_req = 1'b1; ia.phy_req_data = 8'hFF; end
    else          begin ia.mem_req = 1'b1; ia.mem_req_data = 8'hFF; end
    step(1);
    if (side_phy) begin
      chk({tag, "_grant"}, {ia.phy_ack, ia.phy_start, ia.phy_own, ia.busy, ia.phy_data}, 12'hFFF);
      chk({tag, "_other"}, {ia.mem_ack, ia.mem_start, ia.mem_own}, 0);
      ia.phy_req = 1'b0;
    end else begin
      chk({tag, "_grant"}, {ia.mem_ack, ia.mem_start, ia.mem_own, ia.busy, ia.mem_data}, 12'hFFF);
      chk({tag, "_other"}, {ia.phy_ack, ia.phy_start, ia.phy_own}, 0);
      ia.mem_req = 1'b0;
    end
    n = 1;
    other_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (i == 0)
        chk({tag, "_pulse"}, side_phy ? {ia.phy_ack, ia.phy_start} : {ia.mem_ack, ia.mem_start}, 0);
      other_seen |= side_phy ? (ia.mem_own | ia.mem_ack) : (ia.phy_own | ia.phy_ack);
      if (!(side_phy ? ia.phy_own : ia.mem_own)) break;
      n++;
    end
    chk({tag, "_own_len"}, n, 13);
    chk({tag, "_other_quiet"}, {31'd0, other_seen}, 0);
    chk({tag, "_turn1"}, {31'd0, ia.busy}, 1);
    step(1);
    chk({tag, "_turn2"}, {30'd0, ia.busy, ia.phy_own | ia.mem_own}, 2);
    step(1);
    chk({tag, "_idle"}, {31'd0, ia.busy}, 0);
    chk({tag, "_held"}, side_phy ? ia.phy_data : ia.mem_data, 8'hFF);
  endtask

  // Both request on the same edge; the loser is acked 16 cycles after the winner.
  task automatic pair(input bit phy_first, input string tag);
    int n = 0;
    ia.phy_req = 1'b1; ia.phy_req_data = 8'hAA;
    ia.mem_req = 1'b1; ia.mem_req_data = 8'hA5;
    step(1);
    if (phy_first) begin
      chk({tag, "_first"}, {ia.phy_ack, ia.mem_ack, ia.phy_data}, {2'b10, 8'hAA});
      ia.phy_req = 1'b0;
    end else begin
      chk({tag, "_first"}, {ia.phy_ack, ia.mem_ack, ia.mem_data}, {2'b01, 8'hA5});
      ia.mem_req = 1'b0;
    end
    while (n < 40) begin
      step(1);
      n++;
      if (phy_first ? ia.mem_ack : ia.phy_ack) break;
    end
    chk({tag, "_gap"}, n, 16);
    if (phy_first) begin
      chk({tag, "_second"}, {ia.mem_start, ia.mem_own, ia.mem_data}, {2'b11, 8'hA5});
      ia.mem_req = 1'b0;
    end else begin
      chk({tag, "_second"}, {ia.phy_start, ia.phy_own, ia.phy_data}, {2'b11, 8'hAA});
      ia.phy_req = 1'b0;
    end
    wait_idle_a({tag, "_done"});
  endtask

  initial begin
    int n;
    ia.phy_req = 1'b0; ia.phy_req_data = '0; ia.mem_req = 1'b0; ia.mem_req_data = '0;
    ib.phy_req = 1'b0; ib.phy_req_data = '0; ib.mem_req = 1'b0; ib.mem_req_data = '0;

    step(3);
    chk("reset_a", {ia.phy_ack, ia.mem_ack, ia.phy_start, ia.mem_start, ia.phy_own,
                    ia.mem_own, ia.busy, ia.phy_data, ia.mem_data}, 0);
    chk("reset_b", {ib.phy_ack, ib.mem_ack, ib.phy_start, ib.mem_start, ib.phy_own,
                    ib.mem_own, ib.busy, ib.phy_data, ib.mem_data}, 0);
    rst = 1'b0;
    step(2);

    lone(1'b1, "lone_phy");
    // PHY won last, so a tie now goes to MEM.
    pair(1'b0, "pair_mem_first");
    lone(1'b0, "lone_mem");

    rst = 1'b1;
    step(1);
    rst = 1'b0;
    pair(1'b1, "pair_after_reset");

    ia.phy_req = 1'b1; ia.phy_req_data = 8'h5A;
    step(1);
    chk("stag_phy", {ia.phy_ack, ia.mem_ack, ia.phy_data}, {2'b10, 8'h5A});
    ia.phy_req = 1'b0;
    ia.mem_req = 1'b1; ia.mem_req_data = 8'hA5;
    n = 0;
    while (n < 40) begin
      step(1);
      n++;
      if (ia.mem_ack) break;
    end
    chk("stag_gap", n, 16);
    chk("stag_mem", {ia.mem_start, ia.mem_data, ia.phy_data}, {1'b1, 8'hA5, 8'h5A});
    ia.mem_req = 1'b0;
    wait_idle_a("stag_done");

    ia.phy_req = 1'b1; ia.phy_req_data = 8'h3C;
    step(1);
    chk("rst_grant", {ia.phy_ack, ia.phy_data}, {1'b1, 8'h3C});
    step(5);
    chk("rst_in_xfer", {ia.phy_own, ia.busy, ia.phy_ack}, 3'b110);
    rst = 1'b1;
    step(1);
    chk("rst_clear", {ia.phy_ack, ia.mem_ack, ia.phy_start, ia.mem_start, ia.phy_own,
                      ia.mem_own, ia.busy, ia.phy_data, ia.mem_data}, 0);
    rst = 1'b0;
    step(1);
    chk("rst_regrant", {ia.phy_ack, ia.phy_start, ia.phy_own, ia.phy_data}, {3'b111, 8'h3C});
    ia.phy_req = 1'b0;
    wait_idle_a("rst_done");

    ib.phy_req = 1'b1; ib.phy_req_data = 8'h11;
    step(1);
    chk("ta0_phy", {ib.phy_ack, ib.phy_own, ib.phy_data}, {2'b11, 8'h11});
    ib.phy_req = 1'b0;
    ib.mem_req = 1'b1; ib.mem_req_data = 8'h22;
    n = 0;
    while (ib.phy_own && n < 30) begin
      step(1);
      n++;
    end
    chk("ta0_own_len", n, 13);
    chk("ta0_drop", {ib.mem_start, ib.mem_own, ib.busy}, 0);
    step(1);
    chk("ta0_second", {ib.mem_start, ib.mem_ack, ib.mem_own, ib.phy_own, ib.mem_data},
        {4'b1110, 8'h22});
    ib.mem_req = 1'b0;

    chk("no_overlap", {31'd0, overlap_seen}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bidir_link_arbiter.md
Name: bidir_link_arbiter

Overview:
- Arbitrates one shared bidirectional serial link between two requesters: the PHY side and the MEM side.
- Grants one side at a time and issues a one-cycle start pulse plus a byte to that side's wrapper.
- Holds the link for a fixed transfer window, then inserts a bus-turnaround gap in which neither side may drive.
- Sits between the requesting logic and the phy/mem wrappers, ahead of the PCB delay model, so the two ends never drive the link at the same time.

Parameters:
- DATA_W, 8, width of the request/transfer data word.
- XFER_CYCLES, 12, cycles the granted side owns the link after its start pulse (covers serialisation plus flight delay); legal 1..255.
- TA_CYCLES, 2, turnaround idle cycles after every transfer; legal 0..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- phy_req  in  1  PHY-side transfer request; level, held until phy_ack.
- phy_req_data  in  DATA_W  byte to send from the PHY side; valid while phy_req.
- mem_req  in  1  MEM-side transfer request; level, held until mem_ack.
- mem_req_data  in  DATA_W  byte to send from the MEM side; valid while mem_req.
- phy_ack  out  1  one-cycle pulse: PHY request accepted.
- mem_ack  out  1  one-cycle pulse: MEM request accepted.
- phy_start  out  1  start pulse to phy_wrapper.
- phy_data  out  DATA_W  data to phy_wrapper; registered, held after start.
- mem_start  out  1  start pulse to mem_wrapper.
- mem_data  out  DATA_W  data to mem_wrapper; registered, held after start.
- phy_own  out  1  PHY side owns the link (drive enable qualifier).
- mem_own  out  1  MEM side owns the link.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, every output 0, counters 0, rr_last=MEM so PHY wins the first tie.
- All outputs are registered. phy_own and mem_own are never both 1. ack and start are never both high for both sides.
- FSM states: IDLE, START, XFER, TURN.
- IDLE:
  - Sample requests. If exactly one is high, grant it.
  - If both are high, grant the side not equal to rr_last.
  - On grant (next edge): state=START; latch the winner's data into its *_data output; set its *_own=1; set rr_last=winner.
- START (1 cycle):
  - Winner's *_ack=1 and *_start=1 for exactly this cycle.
  - Load cnt=XFER_CYCLES-1; go to XFER.
- XFER:
  - *_own stays 1; decrement cnt.
  - When cnt==0: clear *_own. Go to TURN if TA_CYCLES>0 (load cnt=TA_CYCLES-1), else go to IDLE.
- TURN: both own=0; decrement cnt; at cnt==0 go to IDLE.
- Latency:
  - Request seen in IDLE at edge N → ack and start high in cycle N+1.
  - Link released after XFER_CYCLES+1 cycles of ownership.
  - Next grant no earlier than TA_CYCLES+1 cycles after own drops.
- Requests arriving while busy are held by the requester and serviced in IDLE. There is no queueing inside the block.
- A request that drops before ack is simply not granted. Data is sampled only on the grant edge.
- The losing side in a simultaneous request is guaranteed the next grant, because rr_last alternates.
- Reset mid-transfer: return to IDLE next edge, own/start/ack cleared immediately, pending transfer lost.
- Counter width: clog2(max(XFER_CYCLES,TA_CYCLES)+1).

Decomposition:
- Package bidir_link_pkg:
  - typedef enum logic[1:0] {IDLE, START, XFER, TURN} link_state_e;
  - typedef enum logic {SIDE_PHY, SIDE_MEM} link_side_e;
  - default localparams for DATA_W, XFER_CYCLES, TA_CYCLES.
- One natural sub-module: rr_pick2, the two-requester round-robin picker (combinational grant plus rr_last register). The FSM and counters stay in the top.

Test Plan:
- Lone PHY request: phy_req=1, data 0xFF, 2 cycles after reset → phy_ack and phy_start high 1 cycle later; phy_data=0xFF; phy_own high for 13 cycles; 2 TURN cycles; busy drops; mem_* stay 0.
- Lone MEM request: mem_req, data 0xFF → mirror of the previous case on the mem_* outputs; phy_own stays 0 throughout.
- Simultaneous requests after reset: phy 0xAA, mem 0xA5 on the same edge → PHY served first. MEM is then acked exactly 16 cycles after phy_ack (1+12+2+1), with mem_data=0xA5; own signals never overlap.
- Staggered requests: PHY 0x5A, MEM 0xA5 one cycle later → PHY granted. MEM held pending and granted after TURN. A second simultaneous pair then goes MEM-first, proving rr_last alternation.
- Reset mid-XFER: assert rst at XFER cycle 5 → next edge all outputs 0 and state IDLE. A held request is re-granted 1 cycle after rst deasserts.
- TA_CYCLES=0 build: back-to-back requests → second start occurs 1 cycle after the first own drops; own signals never overlap.
